wb_tag_pipe: RTL and testbench
==============================

Name: wb_tag_pipe

Overview:
- Produces the write-back tags that the decode-stage forwarding/hazard unit consumes: destination scalar/vector addresses, MEM_read and V_reduce flags.
- Carries these tags through the DE/EX, EX/MEM and MEM/WB pipeline registers.
- Inserts bubbles on decode stall and flush; freezes on global hold.
- Counts hazard-stall cycles for performance monitoring.

Parameters:
- S_AW, 5, scalar register address width
- V_AW, 4, vector register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- DE_valid  in  1  decode stage holds a valid instruction
- DE_S_we  in  1  decode instruction writes a scalar register
- DE_Swb_address  in  S_AW  scalar destination
- DE_V_we  in  1  decode instruction writes a vector register
- DE_Vwb_address  in  V_AW  vector destination
- DE_MEM_read  in  1  decode instruction is a load
- DE_V_reduce  in  1  decode instruction is a vector reduce
- DE_stall  in  1  load-use stall request from the hazard unit
- pipe_hold  in  1  global freeze (memory not ready)
- flush  in  1  kill younger instructions; branch resolved in EX/MEM
- DE_EX_Swb_address  out  S_AW
- DE_EX_Vwb_address  out  V_AW
- DE_EX_MEM_read  out  1
- DE_EX_V_reduce  out  1
- EX_MEM_Swb_address  out  S_AW
- EX_MEM_Vwb_address  out  V_AW
- MEM_WB_Swb_address  out  S_AW
- MEM_WB_Vwb_address  out  V_AW
- MEM_WB_S_we  out  1
- MEM_WB_V_we  out  1
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Stage tag fields: {valid, s_we, s_addr, v_we, v_addr, mem_read, v_reduce}. Three stages: DE/EX, EX/MEM, MEM/WB.
- Reset: rst_n low clears all tags to zero immediately, independent of clk. stall_count = 0. Every output is 0 while in reset. Reset asserted mid-operation discards all in-flight tags.
- Update rules on each rising clk edge, first matching rule wins:
  - pipe_hold=1: all stages and stall_count hold. flush and DE_stall are ignored; the branch unit keeps flush high until a non-hold cycle.
  - flush=1: DE/EX <= bubble; EX/MEM <= bubble; MEM/WB <= old EX/MEM, so the branch itself retires.
  - Otherwise: MEM/WB <= EX/MEM; EX/MEM <= DE/EX; DE/EX <= decode fields with valid=1 if DE_valid && !DE_stall, else bubble.
- Bubble definition: all fields 0.
- Output gating (combinational from stage registers):
  - Swb address outputs = s_addr if valid && s_we, else 0.
  - Vwb address outputs = v_addr if valid && v_we, else 0.
  - MEM_read, V_reduce, S_we and V_we outputs are ANDed with valid.
  - Address 0 is the null tag. Reads of R0/V0 may raise a spurious stall in the consumer; this is accepted.
- Latency: with no hold, an instruction accepted at edge k appears on DE_EX after k, on EX_MEM after k+1, and on MEM_WB after k+2. The MEM_WB tag lasts exactly one cycle.
- stall_count: increments when DE_valid && DE_stall && !pipe_hold && !flush. Saturates at all-ones with no wrap.
- Simultaneous DE_stall and flush: flush wins and the cycle is not counted.
- Tags are carried only. No data is stored; register-file data paths live elsewhere.

Decomposition:
- Package rt_pipe_pkg holds:
  - typedef struct packed wb_tag_t (fields as above)
  - localparam wb_tag_t WB_TAG_BUBBLE = '0
  - S_NULL = 5'd0, V_NULL = 4'd0
- Sub-module wb_tag_stage: one wb_tag_t register with hold/bubble/load controls and async active-low clear. It is instantiated three times.
- The top level contains the priority logic, output gating and the counter.

Test Plan:
- Reset mid-flow: tags in all stages, rst_n low between edges -> all outputs 0 at once; after release, the first accepted instruction appears after one edge.
- Flow: DE_valid=1, S_we=1, Swb=7, MEM_read=1 at edge 1 -> edge 1: DE_EX_Swb=7, DE_EX_MEM_read=1; edge 2: EX_MEM_Swb=7; edge 3: MEM_WB_Swb=7, MEM_WB_S_we=1; edge 4: 0.
- Stall: DE_stall=1 with Swb=9 for one cycle -> DE_EX_Swb=0, stall_count=1; DE_stall=0 next cycle -> DE_EX_Swb=9, older tags advance normally.
- Hold: pipe_hold=1 for 3 cycles with DE_stall=1 -> all outputs frozen, stall_count unchanged; release -> normal advance.
- Flush: EX/MEM Vwb=3 (V_we=1), DE/EX Swb=4, decode Swb=5, flush=1 -> MEM_WB_Vwb=3, EX_MEM and DE_EX outputs 0, Swb 5 never appears.
- Gating/saturation: S_we=0 with Swb=12 -> all Swb outputs stay 0; 65,540 stall cycles -> stall_count=16'hFFFF and holds.

Source files
------------

// File: rtl/rt_pipe_pkg.sv
// Shared types and widths for the write-back tag pipeline that feeds
// decode-stage forwarding and hazard detection.
package rt_pipe_pkg;

    localparam int unsigned S_AW = 5;
    localparam int unsigned V_AW = 4;

    typedef struct packed {
        logic            valid;
        logic            s_we;
        logic [S_AW-1:0] s_addr;
        logic            v_we;
        logic [V_AW-1:0] v_addr;
        logic            mem_read;
        logic            v_reduce;
    } wb_tag_t;

    localparam wb_tag_t WB_TAG_BUBBLE = '0;

    localparam logic [S_AW-1:0] S_NULL = 5'd0;
    localparam logic [V_AW-1:0] V_NULL = 4'd0;

endpackage

// File: rtl/wb_tag_stage.sv
// One pipeline register of write-back tags. Hold beats bubble, and bubble
// beats load.
module wb_tag_stage
    import rt_pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold,
    input  logic    bubble,
    input  wb_tag_t tag_in,
    output wb_tag_t tag_out
);

    wb_tag_t tag_q;
    wb_tag_t tag_d;

    always_comb begin
        tag_d = tag_q;
        if (hold) begin
            tag_d = tag_q;
        end else if (bubble) begin
            tag_d = WB_TAG_BUBBLE;
        end else begin
            tag_d = tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= WB_TAG_BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q;

endmodule

// File: rtl/wb_tag_pipe.sv
// Carries write-back tags through DE/EX, EX/MEM and MEM/WB. It applies the
// hold/flush/stall priority, gates the outputs with valid, and counts stalls.
module wb_tag_pipe
    import rt_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            DE_valid,
    input  logic            DE_S_we,
    input  logic [S_AW-1:0] DE_Swb_address,
    input  logic            DE_V_we,
    input  logic [V_AW-1:0] DE_Vwb_address,
    input  logic            DE_MEM_read,
    input  logic            DE_V_reduce,
    input  logic            DE_stall,
    input  logic            pipe_hold,
    input  logic            flush,
    output logic [S_AW-1:0] DE_EX_Swb_address,
    output logic [V_AW-1:0] DE_EX_Vwb_address,
    output logic            DE_EX_MEM_read,
    output logic            DE_EX_V_reduce,
    output logic [S_AW-1:0] EX_MEM_Swb_address,
    output logic [V_AW-1:0] EX_MEM_Vwb_address,
    output logic [S_AW-1:0] MEM_WB_Swb_address,
    output logic [V_AW-1:0] MEM_WB_Vwb_address,
    output logic            MEM_WB_S_we,
    output logic            MEM_WB_V_we,
    output logic [CNT_W-1:0] stall_count
);

    wb_tag_t de_tag;
    wb_tag_t de_ex;
    wb_tag_t ex_mem;
    wb_tag_t mem_wb;
    logic    de_ex_bubble;
    logic    ex_mem_bubble;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        de_tag          = WB_TAG_BUBBLE;
        de_tag.valid    = 1'b1;
        de_tag.s_we     = DE_S_we;
        de_tag.s_addr   = DE_Swb_address;
        de_tag.v_we     = DE_V_we;
        de_tag.v_addr   = DE_Vwb_address;
        de_tag.mem_read = DE_MEM_read;
        de_tag.v_reduce = DE_V_reduce;
        // A flush kills both younger stages; a stall or an empty decode
        // slot inserts a bubble only at the head.
        de_ex_bubble    = flush | ~DE_valid | DE_stall;
        ex_mem_bubble   = flush;
    end

    wb_tag_stage u_de_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (pipe_hold),
        .bubble  (de_ex_bubble),
        .tag_in  (de_tag),
        .tag_out (de_ex)
    );

    wb_tag_stage u_ex_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (pipe_hold),
        .bubble  (ex_mem_bubble),
        .tag_in  (de_ex),
        .tag_out (ex_mem)
    );

    wb_tag_stage u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (pipe_hold),
        .bubble  (1'b0),
        .tag_in  (ex_mem),
        .tag_out (mem_wb)
    );

    // The stall counter saturates; flush and hold cycles are not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (!pipe_hold && !flush && DE_valid && DE_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        DE_EX_Swb_address  = (de_ex.valid  && de_ex.s_we)  ? de_ex.s_addr  : S_NULL;
        DE_EX_Vwb_address  = (de_ex.valid  && de_ex.v_we)  ? de_ex.v_addr  : V_NULL;
        DE_EX_MEM_read     = de_ex.valid & de_ex.mem_read;
        DE_EX_V_reduce     = de_ex.valid & de_ex.v_reduce;
        EX_MEM_Swb_address = (ex_mem.valid && ex_mem.s_we) ? ex_mem.s_addr : S_NULL;
        EX_MEM_Vwb_address = (ex_mem.valid && ex_mem.v_we) ? ex_mem.v_addr : V_NULL;
        MEM_WB_Swb_address = (mem_wb.valid && mem_wb.s_we) ? mem_wb.s_addr : S_NULL;
        MEM_WB_Vwb_address = (mem_wb.valid && mem_wb.v_we) ? mem_wb.v_addr : V_NULL;
        MEM_WB_S_we        = mem_wb.valid & mem_wb.s_we;
        MEM_WB_V_we        = mem_wb.valid & mem_wb.v_we;
    end

    assign stall_count = cnt_q;

    // The load and reduce flags are consumed only in the DE/EX stage.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{ex_mem.mem_read, ex_mem.v_reduce,
                               mem_wb.mem_read, mem_wb.v_reduce};

endmodule

// File: tb/tb_wb_tag_pipe.sv
// Bench for wb_tag_pipe: directed stimulus, a queue-style tag model checked
// every cycle, and literal expectations at the key points.
module tb_wb_tag_pipe;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_MAX = 65535;

    typedef struct {
        bit       v;
        bit       swe;
        bit [4:0] sa;
        bit       vwe;
        bit [3:0] va;
        bit       mr;
        bit       vr;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       DE_valid, DE_S_we, DE_V_we, DE_MEM_read, DE_V_reduce;
    logic [4:0] DE_Swb_address;
    logic [3:0] DE_Vwb_address;
    logic       DE_stall, pipe_hold, flush;
    logic [4:0] DE_EX_Swb_address, EX_MEM_Swb_address, MEM_WB_Swb_address;
    logic [3:0] DE_EX_Vwb_address, EX_MEM_Vwb_address, MEM_WB_Vwb_address;
    logic       DE_EX_MEM_read, DE_EX_V_reduce, MEM_WB_S_we, MEM_WB_V_we;
    logic [CNT_W-1:0] stall_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rec_t        pipe [3];   // 0 = DE/EX, 1 = EX/MEM, 2 = MEM/WB
    int unsigned m_cnt;

    wb_tag_pipe #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .DE_valid           (DE_valid),
        .DE_S_we            (DE_S_we),
        .DE_Swb_address     (DE_Swb_address),
        .DE_V_we            (DE_V_we),
        .DE_Vwb_address     (DE_Vwb_address),
        .DE_MEM_read        (DE_MEM_read),
        .DE_V_reduce        (DE_V_reduce),
        .DE_stall           (DE_stall),
        .pipe_hold          (pipe_hold),
        .flush              (flush),
        .DE_EX_Swb_address  (DE_EX_Swb_address),
        .DE_EX_Vwb_address  (DE_EX_Vwb_address),
        .DE_EX_MEM_read     (DE_EX_MEM_read),
        .DE_EX_V_reduce     (DE_EX_V_reduce),
        .EX_MEM_Swb_address (EX_MEM_Swb_address),
        .EX_MEM_Vwb_address (EX_MEM_Vwb_address),
        .MEM_WB_Swb_address (MEM_WB_Swb_address),
        .MEM_WB_Vwb_address (MEM_WB_Vwb_address),
        .MEM_WB_S_we        (MEM_WB_S_we),
        .MEM_WB_V_we        (MEM_WB_V_we),
        .stall_count        (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t empty_rec();
        rec_t r;
        r = '{v: 0, swe: 0, sa: 0, vwe: 0, va: 0, mr: 0, vr: 0};
        return r;
    endfunction

    // Reference model: shift-register of instruction records.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = empty_rec();
            m_cnt = 0;
        end else if (!pipe_hold) begin
            if (!flush && DE_valid && DE_stall && m_cnt < CNT_MAX) m_cnt++;
            pipe[2] = pipe[1];
            if (flush) begin
                pipe[1] = empty_rec();
                pipe[0] = empty_rec();
            end else begin
                pipe[1] = pipe[0];
                pipe[0] = empty_rec();
                if (DE_valid && !DE_stall) begin
                    pipe[0].v   = 1;
                    pipe[0].swe = DE_S_we;
                    pipe[0].sa  = DE_Swb_address;
                    pipe[0].vwe = DE_V_we;
                    pipe[0].va  = DE_Vwb_address;
                    pipe[0].mr  = DE_MEM_read;
                    pipe[0].vr  = DE_V_reduce;
                end
            end
        end
    end

    function automatic int unsigned sa_of(input rec_t r);
        return (r.v && r.swe) ? int'(r.sa) : 0;
    endfunction

    function automatic int unsigned va_of(input rec_t r);
        return (r.v && r.vwe) ? int'(r.va) : 0;
    endfunction

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("de_ex_swb",  DE_EX_Swb_address,  sa_of(pipe[0]));
        chk("de_ex_vwb",  DE_EX_Vwb_address,  va_of(pipe[0]));
        chk("de_ex_mr",   DE_EX_MEM_read,     pipe[0].v && pipe[0].mr);
        chk("de_ex_vr",   DE_EX_V_reduce,     pipe[0].v && pipe[0].vr);
        chk("ex_mem_swb", EX_MEM_Swb_address, sa_of(pipe[1]));
        chk("ex_mem_vwb", EX_MEM_Vwb_address, va_of(pipe[1]));
        chk("mem_wb_swb", MEM_WB_Swb_address, sa_of(pipe[2]));
        chk("mem_wb_vwb", MEM_WB_Vwb_address, va_of(pipe[2]));
        chk("mem_wb_swe", MEM_WB_S_we,        pipe[2].v && pipe[2].swe);
        chk("mem_wb_vwe", MEM_WB_V_we,        pipe[2].v && pipe[2].vwe);
        chk("stall_cnt",  stall_count,        m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic swe, input logic [4:0] sa,
                         input logic vwe, input logic [3:0] va, input logic mr);
        DE_valid       = v;
        DE_S_we        = swe;
        DE_Swb_address = sa;
        DE_V_we        = vwe;
        DE_Vwb_address = va;
        DE_MEM_read    = mr;
        DE_V_reduce    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_z_swb"}, {DE_EX_Swb_address, EX_MEM_Swb_address, MEM_WB_Swb_address}, 0);
        chk({tag, "_z_vwb"}, {DE_EX_Vwb_address, EX_MEM_Vwb_address, MEM_WB_Vwb_address}, 0);
        chk({tag, "_z_flg"}, {DE_EX_MEM_read, DE_EX_V_reduce, MEM_WB_S_we, MEM_WB_V_we}, 0);
        chk({tag, "_z_cnt"}, stall_count, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        DE_stall = 0; pipe_hold = 0; flush = 0;
        #12;
        chk_all_zero("por");
        @(negedge clk); #1 rst_n = 1'b1;

        // Flow: load through all three stages.
        drive(1, 1, 5'd7, 0, 0, 1);
        tick();
        chk("flow_e1_swb", DE_EX_Swb_address, 7);
        chk("flow_e1_mr",  DE_EX_MEM_read, 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("flow_e2_swb", EX_MEM_Swb_address, 7);
        tick();
        chk("flow_e3_swb", MEM_WB_Swb_address, 7);
        chk("flow_e3_swe", MEM_WB_S_we, 1);
        tick();
        chk("flow_e4_swb", MEM_WB_Swb_address, 0);

        // Stall for one cycle, then accept.
        drive(1, 1, 5'd9, 0, 0, 0);
        DE_stall = 1;
        tick();
        chk("stall_swb", DE_EX_Swb_address, 0);
        chk("stall_cnt", stall_count, 1);
        DE_stall = 0;
        tick();
        chk("unstall_swb", DE_EX_Swb_address, 9);

        // Hold with a pending stall freezes everything.
        drive(1, 0, 0, 1, 4'd2, 0);
        tick();
        pipe_hold = 1; DE_stall = 1; drive(1, 1, 5'd11, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("hold_de_vwb",  DE_EX_Vwb_address, 2);
        chk("hold_ex_swb",  EX_MEM_Swb_address, 9);
        chk("hold_cnt",     stall_count, 1);
        pipe_hold = 0; DE_stall = 0; drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("rel_ex_vwb", EX_MEM_Vwb_address, 2);
        chk("rel_wb_swb", MEM_WB_Swb_address, 9);

        // Flush: branch in EX/MEM retires, younger tags die, stall ignored.
        drive(1, 0, 0, 1, 4'd3, 0);
        tick();
        drive(1, 1, 5'd4, 0, 0, 0);
        tick();
        drive(1, 1, 5'd5, 0, 0, 0);
        flush = 1; DE_stall = 1;
        tick();
        chk("flush_wb_vwb", MEM_WB_Vwb_address, 3);
        chk("flush_wb_vwe", MEM_WB_V_we, 1);
        chk("flush_ex_swb", EX_MEM_Swb_address, 0);
        chk("flush_de_swb", DE_EX_Swb_address, 0);
        chk("flush_cnt",    stall_count, 1);
        flush = 0; DE_stall = 0; drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_swb5", (MEM_WB_Swb_address == 5'd5) ? 1 : 0, 0);
        end

        // Gating: s_we=0 keeps the address hidden.
        drive(1, 0, 5'd12, 0, 4'd6, 0);
        tick();
        chk("gate_de_swb", DE_EX_Swb_address, 0);
        chk("gate_de_vwb", DE_EX_Vwb_address, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("gate_wb_swb", MEM_WB_Swb_address, 0);

        // Reset mid-flow between edges.
        drive(1, 1, 5'd13, 1, 4'd7, 1);
        for (int i = 0; i < 3; i++) tick();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid");
        @(negedge clk); #1 rst_n = 1'b1;
        drive(1, 1, 5'd6, 0, 0, 0);
        tick();
        chk("post_rst_swb", DE_EX_Swb_address, 6);
        chk("post_rst_ex",  EX_MEM_Swb_address, 0);

        // Saturation of the stall counter.
        DE_stall = 1;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_cnt", stall_count, 16'hFFFF);
        tick();
        chk("sat_hold", stall_count, 16'hFFFF);
        DE_stall = 0; drive(0, 0, 0, 0, 0, 0);
        tick();

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
